cpcs_tx_framer: RTL

//  Tx framing stage directly upstream of the 8b/10b encoder; drives its D/K inputs.

---
 rtl/cpcs_tx_framer_if.sv | 22 ++
 rtl/cpcs_tx_framer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cpcs_tx_framer_if.sv
// Byte-stream handshake between a packet source and the Tx framer.
// The source drives data/valid/last and holds them until ready accepts the byte.
interface cpcs_tx_framer_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      output tx_last,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      input  tx_last,
      output tx_ready
   );
endinterface

// File: rtl/cpcs_tx_framer.sv
// Tx framing stage ahead of the 8b/10b encoder: wraps source packets in SOP/EOP,
// fills gaps with K28.5 idle pairs on even slots and spaces frames by a minimum gap.
module cpcs_tx_framer #(
   parameter int unsigned MIN_IPG = 2,
   parameter logic [7:0]  IDLE_D  = 8'hC5
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            tx_en_i,
   cpcs_tx_framer_if.slave src_if,
   output logic [7:0]      enc_d_o,
   output logic            enc_k_o,
   output logic            frame_active_o,
   output logic            err_underrun_o,
   output logic [15:0]     frame_cnt_o
);

   localparam int unsigned IPG_CLAMP = (MIN_IPG < 1) ? 1 : ((MIN_IPG > 15) ? 15 : MIN_IPG);
   localparam logic [3:0]  IPG_MIN   = 4'(IPG_CLAMP);

   localparam logic [7:0] SYM_K285 = 8'hBC;
   localparam logic [7:0] SYM_SOP  = 8'hFB;
   localparam logic [7:0] SYM_EOP  = 8'hFD;
   localparam logic [7:0] SYM_EXT  = 8'hF7;
   localparam logic [7:0] SYM_ERR  = 8'hFE;

   typedef enum logic [2:0] {
      S_IDLE_K = 3'd0,
      S_IDLE_D = 3'd1,
      S_SOP    = 3'd2,
      S_DATA   = 3'd3,
      S_EOP    = 3'd4,
      S_EXT    = 3'd5
   } state_t;

   function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
      logic [3:0] res;
      if (val >= lim) begin
         res = lim;
      end else begin
         res = val + 4'd1;
      end
      return res;
   endfunction

   // The gap counter is compared one ahead because the current idle pair is still being sent.
   function automatic logic ipg_met(input logic [3:0] cnt);
      return (({1'b0, cnt} + 5'd1) >= {1'b0, IPG_MIN});
   endfunction

   state_t      state_q, state_d;
   logic        parity_q, parity_d;
   logic [3:0]  ipg_cnt_q, ipg_cnt_d;
   logic [7:0]  enc_d_q, enc_d_d;
   logic        enc_k_q, enc_k_d;
   logic        frame_active_q, frame_active_d;
   logic        err_underrun_q, err_underrun_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        next_slot_even_s;

   // parity_q is the slot of the symbol on the outputs now; the one being loaded has the other parity.
   assign next_slot_even_s = parity_q;

   assign src_if.tx_ready = (state_q == S_DATA);

   // Next-state and symbol selection for the slot loaded at the coming edge.
   always_comb begin
      state_d        = state_q;
      parity_d       = ~parity_q;
      ipg_cnt_d      = ipg_cnt_q;
      enc_d_d        = enc_d_q;
      enc_k_d        = enc_k_q;
      frame_active_d = 1'b0;
      err_underrun_d = 1'b0;
      frame_cnt_d    = frame_cnt_q;

      case (state_q)
         S_IDLE_K: begin
            if (next_slot_even_s) begin
               enc_d_d = SYM_K285;
               enc_k_d = 1'b1;
               state_d = S_IDLE_D;
            end else begin
               enc_d_d = IDLE_D;
               enc_k_d = 1'b0;
               state_d = S_IDLE_K;
            end
         end
         S_IDLE_D: begin
            enc_d_d   = IDLE_D;
            enc_k_d   = 1'b0;
            ipg_cnt_d = sat_inc(ipg_cnt_q, IPG_MIN);
            if (tx_en_i && src_if.tx_valid && ipg_met(ipg_cnt_q)) begin
               state_d = S_SOP;
            end else begin
               state_d = S_IDLE_K;
            end
         end
         S_SOP: begin
            enc_d_d        = SYM_SOP;
            enc_k_d        = 1'b1;
            frame_active_d = 1'b1;
            state_d        = S_DATA;
         end
         S_DATA: begin
            frame_active_d = 1'b1;
            if (src_if.tx_valid) begin
               enc_d_d = src_if.tx_data;
               enc_k_d = 1'b0;
               if (src_if.tx_last) begin
                  state_d = S_EOP;
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               // Underrun: abort with an error symbol; the source's remaining bytes start a new frame.
               enc_d_d        = SYM_ERR;
               enc_k_d        = 1'b1;
               err_underrun_d = 1'b1;
               state_d        = S_EOP;
            end
         end
         S_EOP: begin
            enc_d_d        = SYM_EOP;
            enc_k_d        = 1'b1;
            frame_active_d = 1'b1;
            ipg_cnt_d      = 4'd0;
            frame_cnt_d    = frame_cnt_q + 16'd1;
            if (next_slot_even_s) begin
               state_d = S_EXT;
            end else begin
               state_d = S_IDLE_K;
            end
         end
         S_EXT: begin
            enc_d_d = SYM_EXT;
            enc_k_d = 1'b1;
            state_d = S_IDLE_K;
         end
         default: begin
            enc_d_d = IDLE_D;
            enc_k_d = 1'b0;
            state_d = S_IDLE_K;
         end
      endcase
   end

   // State and registered encoder outputs; reset leaves K28.5 on an even slot.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= S_IDLE_D;
         parity_q       <= 1'b0;
         ipg_cnt_q      <= IPG_MIN;
         enc_d_q        <= SYM_K285;
         enc_k_q        <= 1'b1;
         frame_active_q <= 1'b0;
         err_underrun_q <= 1'b0;
         frame_cnt_q    <= 16'd0;
      end else begin
         state_q        <= state_d;
         parity_q       <= parity_d;
         ipg_cnt_q      <= ipg_cnt_d;
         enc_d_q        <= enc_d_d;
         enc_k_q        <= enc_k_d;
         frame_active_q <= frame_active_d;
         err_underrun_q <= err_underrun_d;
         frame_cnt_q    <= frame_cnt_d;
      end
   end

   assign enc_d_o        = enc_d_q;
   assign enc_k_o        = enc_k_q;
   assign frame_active_o = frame_active_q;
   assign err_underrun_o = err_underrun_q;
   assign frame_cnt_o    = frame_cnt_q;

endmodule
